// File: rtl/pipe_hold_ctrl_if.sv
// Hazard-request and hold-control bundle between the pipeline stages and pipe_hold_ctrl.
// slave = controller side, master = pipeline side.
interface pipe_hold_ctrl_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 32;

    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              load_use_i;
    logic              div_busy_i;
    logic              mem_wait_i;

    logic [1:0]        hold_flag_o;
    logic              ex_hold_o;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;
    logic              stall_timeout_o;

    modport slave (
        input  jump_flag_i, jump_addr_i, load_use_i, div_busy_i, mem_wait_i,
        output hold_flag_o, ex_hold_o, jump_flag_o, jump_addr_o,
               stall_cnt_o, flush_cnt_o, stall_timeout_o
    );

    modport master (
        output jump_flag_i, jump_addr_i, load_use_i, div_busy_i, mem_wait_i,
        input  hold_flag_o, ex_hold_o, jump_flag_o, jump_addr_o,
               stall_cnt_o, flush_cnt_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: resolves stall and redirect requests by fixed priority,
// sequences the two-cycle wrong-path flush, and keeps stall/flush counters plus a stall watchdog.
module pipe_hold_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    pipe_hold_ctrl_if.slave bus
);
    localparam int unsigned WD_W   = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned ADDR_W = 64;

    localparam logic [1:0] HOLD_RUN       = 2'b00;
    localparam logic [1:0] HOLD_STALL     = 2'b01;
    localparam logic [1:0] HOLD_FLUSH_IF  = 2'b10;
    localparam logic [1:0] HOLD_FLUSH_ALL = 2'b11;

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_FLUSH2 = 2'b01,
        S_WAIT   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        hold_c;
    logic              ex_hold_c;
    logic              accept_c;
    logic              wait_req_c;
    logic              stall_c;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;

    assign wait_req_c = bus.mem_wait_i | bus.div_busy_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: mem_wait > div_busy > jump > (pending flush) > load_use.
    always_comb begin
        state_d   = state_q;
        hold_c    = HOLD_RUN;
        ex_hold_c = 1'b0;
        accept_c  = 1'b0;
        unique case (state_q)
            S_FLUSH2: begin
                if (wait_req_c) begin
                    hold_c    = HOLD_STALL;
                    ex_hold_c = 1'b1;
                    state_d   = S_WAIT;
                end else if (bus.jump_flag_i) begin
                    hold_c   = HOLD_FLUSH_ALL;
                    accept_c = 1'b1;
                    state_d  = S_FLUSH2;
                end else begin
                    hold_c  = HOLD_FLUSH_IF;
                    state_d = S_RUN;
                end
            end
            S_RUN, S_WAIT: begin
                if (wait_req_c) begin
                    hold_c    = HOLD_STALL;
                    ex_hold_c = 1'b1;
                    state_d   = S_WAIT;
                end else if (bus.jump_flag_i) begin
                    hold_c   = HOLD_FLUSH_ALL;
                    accept_c = 1'b1;
                    state_d  = S_FLUSH2;
                end else if (bus.load_use_i) begin
                    hold_c  = HOLD_STALL;
                    state_d = S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Zero-latency control outputs, forced to idle while reset is held.
    assign bus.hold_flag_o = rst ? hold_c : HOLD_RUN;
    assign bus.ex_hold_o   = rst & ex_hold_c;
    assign bus.jump_flag_o = rst & accept_c;
    assign bus.jump_addr_o = (rst && accept_c) ? bus.jump_addr_i : ADDR_W'(0);

    assign stall_c = (hold_c == HOLD_STALL);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wd_cnt_d    = '0;
        timeout_d   = timeout_q;
        if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (accept_c) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (stall_c) begin
            wd_cnt_d = (wd_cnt_q == {WD_W{1'b1}}) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            // Flag on the same edge the counter reaches the limit.
            if (CNT_W'(wd_cnt_d) >= TIMEOUT) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.stall_cnt_o     = stall_cnt_q;
    assign bus.flush_cnt_o     = flush_cnt_q;
    assign bus.stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl: a per-cycle reference model pushes expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_pipe_hold_ctrl;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [1:0]  hold;
        logic        ex;
        logic        jf;
        logic [63:0] ja;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    pipe_hold_ctrl_if bus ();

    pipe_hold_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model state
    bit      m_pend  = 1'b0;
    longint  m_stall = 0;
    longint  m_flush = 0;
    int      m_wd    = 0;
    bit      m_to    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle_item=%0d actual=%h expected=%h", name, popped, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            popped++;
            chk("hold_flag",     64'(bus.hold_flag_o),     64'(e.hold));
            chk("ex_hold",       64'(bus.ex_hold_o),       64'(e.ex));
            chk("jump_flag",     64'(bus.jump_flag_o),     64'(e.jf));
            chk("jump_addr",     bus.jump_addr_o,          e.ja);
            chk("stall_cnt",     64'(bus.stall_cnt_o),     64'(e.sc));
            chk("flush_cnt",     64'(bus.flush_cnt_o),     64'(e.fc));
            chk("stall_timeout", 64'(bus.stall_timeout_o), 64'(e.to));
        end
    end

    // One clock cycle of stimulus plus the model's expectation for it.
    task automatic step(input bit r, input bit j, input logic [63:0] a,
                        input bit lu, input bit dv, input bit mw);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.jump_flag_i = j;
        bus.jump_addr_i = a;
        bus.load_use_i  = lu;
        bus.div_busy_i  = dv;
        bus.mem_wait_i  = mw;
        e = '0;
        if (!r) begin
            m_pend = 0; m_stall = 0; m_flush = 0; m_wd = 0; m_to = 0;
        end else begin
            e.sc = 32'(m_stall);
            e.fc = 32'(m_flush);
            e.to = m_to;
            if (mw || dv) begin
                e.hold = 2'b01; e.ex = 1'b1; m_pend = 0;
            end else if (j) begin
                e.hold = 2'b11; e.jf = 1'b1; e.ja = a;
                m_flush = (m_flush + 1) % 64'h1_0000_0000;
                m_pend = 1;
            end else if (m_pend) begin
                e.hold = 2'b10; m_pend = 0;
            end else if (lu) begin
                e.hold = 2'b01;
            end
            if (e.hold == 2'b01) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                if (m_wd < 65535) m_wd++;
                if (m_wd >= int'(TO)) m_to = 1;
            end else begin
                m_wd = 0;
            end
        end
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 64'h0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.jump_flag_i = 1'b0;
        bus.jump_addr_i = '0;
        bus.load_use_i  = 1'b0;
        bus.div_busy_i  = 1'b0;
        bus.mem_wait_i  = 1'b0;

        // Reset, then idle: all zero outputs
        for (int i = 0; i < 3; i++) step(0, 0, 64'h0, 0, 0, 0);
        idle(4);

        // Single redirect: 11 + strobe, 10, 00
        step(1, 1, 64'h8000_0040, 0, 0, 0);
        idle(3);

        // Load-use bubble
        step(1, 0, 64'h0, 1, 0, 0);
        idle(2);

        // Divider busy with a held jump, jump one cycle beyond
        for (int i = 0; i < 5; i++) step(1, 1, 64'h0000_1234_5678_9ABC, 0, 1, 0);
        step(1, 1, 64'h0000_1234_5678_9ABC, 0, 0, 0);
        idle(3);

        // Watchdog: four mem-wait cycles reach TIMEOUT
        for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0, 0, 1);
        idle(3);

        // Back-to-back redirect while in the flush cycle, load-use ignored
        step(1, 1, 64'hAAAA_0000_0000_0010, 0, 0, 0);
        step(1, 1, 64'hBBBB_0000_0000_0020, 1, 0, 0);
        step(1, 0, 64'h0, 1, 0, 0);
        idle(2);

        // Reset during FLUSH2 with active inputs, then idle must be 00
        step(1, 1, 64'hDEAD_BEEF_0000_0004, 0, 0, 0);
        step(0, 1, 64'hDEAD_BEEF_0000_0008, 1, 1, 1);
        step(0, 0, 64'h0, 0, 0, 0);
        idle(3);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            bit r;
            r = ($urandom_range(0, 99) != 0);
            step(r, ($urandom_range(0, 3) == 0), {$urandom, $urandom},
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0));
        end
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL scoreboard_drain popped=%0d pushed=%0d", popped, pushed);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
